input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of independent asynchronous input channels.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal 2..4.
REQ-003 Parameter FILTER_LEN, default 4: consecutive stable cycles needed to accept a new level, legal 1..255.
REQ-004 clk  input  1  sole clock; all flops on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  asynchronous channel inputs.
REQ-007 glitch_clr  input  1  synchronous clear of glitch_count.
REQ-008 data_out  output  DATA_WIDTH  synchronised, filtered level per channel.
REQ-009 rise  output  DATA_WIDTH  one-cycle pulse per channel on accepted 0->1.
REQ-010 fall  output  DATA_WIDTH  one-cycle pulse per channel on accepted 1->0.
REQ-011 edge_any  output  1  OR of all rise and fall bits, same cycle.
REQ-012 glitch_count  output  16  saturating count of cycles with at least one rejected pulse.

Function
REQ-013 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-014 Each channel SHALL hold a counter of width clog2(FILTER_LEN+1); all outputs registered, no combinational path from data_in.
REQ-015 Per edge, if sync_q == data_out the counter SHALL clear to 0.
REQ-016 Per edge, if sync_q != data_out and counter < FILTER_LEN-1, the counter SHALL increment.
REQ-017 Per edge, if sync_q != data_out and counter == FILTER_LEN-1, data_out SHALL take sync_q and the counter SHALL clear.
REQ-018 Latency from a stable data_in change to data_out SHALL be exactly SYNC_STAGES+FILTER_LEN clk edges.
REQ-019 A level at sync_q lasting fewer than FILTER_LEN cycles SHALL NOT alter data_out.
REQ-020 rise[i]/fall[i] SHALL be high exactly in the cycle data_out[i] first shows its new value, low otherwise.
REQ-021 Channels SHALL be independent; simultaneous updates on several channels SHALL produce simultaneous pulses.
REQ-022 A rejected pulse is a counter clearing from nonzero via REQ-015; any cycle with one or more rejections SHALL add exactly 1 to glitch_count.
REQ-023 glitch_count SHALL saturate at 16'hFFFF and not wrap.
REQ-024 glitch_clr SHALL set glitch_count to 0 next edge, taking priority over a simultaneous increment.
REQ-025 FILTER_LEN=1 SHALL accept any change on the first differing edge (latency SYNC_STAGES+1), glitch_count stays 0.

Reset
REQ-026 With rst high at an edge, all synchroniser flops, counters, data_out, rise, fall, edge_any and glitch_count SHALL become 0.
REQ-027 Reset-induced changes of data_out SHALL NOT generate rise/fall pulses.
REQ-028 Reset asserted mid-count SHALL discard partial counts; after release, filtering restarts from data_out=0.

Configuration
REQ-029 Macro INPUT_CONDITIONER_FILTER_EN defined: glitch filter per REQ-014..REQ-025 compiled in.
REQ-030 Macro undefined: no counters; data_out SHALL equal sync_q registered one edge later (latency SYNC_STAGES+1), rise/fall per REQ-020, glitch_count tied to 0, FILTER_LEN ignored.

Verification (DATA_WIDTH=8, SYNC_STAGES=2, FILTER_LEN=4, macro defined unless stated)
REQ-031 Release reset, data_in 00->AA held -> data_out=AA exactly 6 edges later, rise=AA one cycle, fall=00, edge_any=1 one cycle.
REQ-032 data_in AA->55 held -> after 6 edges data_out=55, rise=55 and fall=AA same cycle.
REQ-033 From 00, bit0 high for 2 cycles then low -> data_out stays 00, no pulses, glitch_count=1.
REQ-034 Preload glitch_count FFFF via repeated glitches, one more glitch -> stays FFFF; glitch_clr with simultaneous glitch -> 0000.
REQ-035 data_in=FF, rst asserted 3 edges after change -> all outputs 0 next edge, no pulses; after release data_out=FF 6 edges later with rise=FF.
REQ-036 Macro undefined, data_in 00->3C -> data_out=3C 3 edges later, rise=3C; 1-cycle glitch on bit7 at sync_q propagates to data_out.

Source files
------------

// File: rtl/input_conditioner.sv
// Per-channel synchroniser, optional glitch filter and edge pulses.
// Define INPUT_CONDITIONER_FILTER_EN to build the stable-count filter.
module input_conditioner #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  glitch_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall,
  output logic                  edge_any,
  output logic [15:0]           glitch_count
);

  logic [DATA_WIDTH-1:0] sync_chain_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_chain_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic                  edge_any_q, edge_any_d;

  always_comb begin
    sync_chain_d[0] = data_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_chain_d[i] = sync_chain_q[i-1];
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

`ifdef INPUT_CONDITIONER_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0]         cnt_q [DATA_WIDTH];
  logic [CW-1:0]         cnt_d [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] reject;
  logic [15:0]           glitch_count_q, glitch_count_d;

  always_comb begin
    data_out_d = data_out_q;
    reject     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == data_out_q[i]) begin
        cnt_d[i]  = '0;
        reject[i] = (cnt_q[i] != '0);
      end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
        data_out_d[i] = sync_q[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle rejection; count sticks at all-ones.
  always_comb begin
    glitch_count_d = glitch_count_q;
    if (glitch_clr) begin
      glitch_count_d = '0;
    end else if (|reject && glitch_count_q != 16'hFFFF) begin
      glitch_count_d = glitch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_count_q <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      glitch_count_q <= glitch_count_d;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign glitch_count = glitch_count_q;
`else
  logic unused_ok;

  always_comb begin
    data_out_d = sync_q;
  end

  assign unused_ok    = glitch_clr | (FILTER_LEN == 0);
  assign glitch_count = '0;
`endif

  always_comb begin
    rise_d     = data_out_d & ~data_out_q;
    fall_d     = ~data_out_d & data_out_q;
    edge_any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      edge_any_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_any_q <= edge_any_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain_q[i] <= sync_chain_d[i];
      end
    end
  end

  assign data_out = data_out_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_any = edge_any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (8 ch, 2 sync, filter 4).
// Exercises whichever build INPUT_CONDITIONER_FILTER_EN selects.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       glitch_clr;
  logic [7:0] data_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       edge_any;
  logic [15:0] glitch_count;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .FILTER_LEN (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .glitch_clr  (glitch_clr),
    .data_out    (data_out),
    .rise        (rise),
    .fall        (fall),
    .edge_any    (edge_any),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, "_dout"}, 32'(data_out), 32'h00);
    chk({tag, "_rise"}, 32'(rise), 32'h00);
    chk({tag, "_fall"}, 32'(fall), 32'h00);
    chk({tag, "_edge"}, 32'(edge_any), 32'h0);
    chk({tag, "_gcnt"}, 32'(glitch_count), 32'h0);
  endtask

  initial begin
    logic [7:0] pulses;
    rst        = 1'b1;
    data_in    = 8'h00;
    glitch_clr = 1'b0;
    repeat (3) step();
    chk_zero_all("reset");
    rst = 1'b0;
    repeat (3) step();
    chk("idle_dout", 32'(data_out), 32'h00);

`ifdef INPUT_CONDITIONER_FILTER_EN
    data_in = 8'hAA;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("aa_wait", 32'(data_out), 32'h00);
    end
    step();
    chk("aa_dout", 32'(data_out), 32'hAA);
    chk("aa_rise", 32'(rise), 32'hAA);
    chk("aa_fall", 32'(fall), 32'h00);
    chk("aa_edge", 32'(edge_any), 32'h1);
    step();
    chk("aa_rise_off", 32'(rise), 32'h00);
    chk("aa_edge_off", 32'(edge_any), 32'h0);

    data_in = 8'h55;
    repeat (5) step();
    chk("55_wait", 32'(data_out), 32'hAA);
    step();
    chk("55_dout", 32'(data_out), 32'h55);
    chk("55_rise", 32'(rise), 32'h55);
    chk("55_fall", 32'(fall), 32'hAA);
    chk("55_edge", 32'(edge_any), 32'h1);

    data_in = 8'h00;
    repeat (6) step();
    chk("00_dout", 32'(data_out), 32'h00);
    chk("00_fall", 32'(fall), 32'h55);
    chk("clean_gcnt", 32'(glitch_count), 32'h0);

    pulses  = 8'h00;
    data_in = 8'h01;
    step();
    pulses |= rise | fall;
    step();
    pulses |= rise | fall;
    data_in = 8'h00;
    repeat (8) begin
      step();
      pulses |= rise | fall;
    end
    chk("glitch_dout", 32'(data_out), 32'h00);
    chk("glitch_pulse", 32'(pulses), 32'h00);
    chk("glitch_gcnt", 32'(glitch_count), 32'h1);

    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    chk("clr_gcnt", 32'(glitch_count), 32'h0);

    // Opposite-phase channels give one rejection every cycle
    data_in = 8'h55;
    for (int n = 1; n <= 65600; n++) begin
      step();
      if (n == 100) chk("sat_100", 32'(glitch_count), 32'd97);
      if (n == 65537) chk("sat_fffe", 32'(glitch_count), 32'hFFFE);
      if (n == 65538) chk("sat_ffff", 32'(glitch_count), 32'hFFFF);
      data_in = ~data_in;
    end
    chk("sat_hold", 32'(glitch_count), 32'hFFFF);
    chk("sat_dout", 32'(data_out), 32'h00);
    glitch_clr = 1'b1;
    step();
    data_in    = ~data_in;
    glitch_clr = 1'b0;
    chk("sat_clr", 32'(glitch_count), 32'h0);
    step();
    chk("sat_restart", 32'(glitch_count), 32'h1);
    data_in = 8'h00;
    repeat (6) step();
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;

    data_in = 8'hFF;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_zero_all("midrst");
    rst = 1'b0;
    repeat (5) step();
    chk("rel_wait", 32'(data_out), 32'h00);
    step();
    chk("rel_dout", 32'(data_out), 32'hFF);
    chk("rel_rise", 32'(rise), 32'hFF);

    rst = 1'b1;
    step();
    chk_zero_all("rst_hi");
    rst = 1'b0;
`else
    data_in = 8'h3C;
    repeat (2) step();
    chk("3c_wait", 32'(data_out), 32'h00);
    step();
    chk("3c_dout", 32'(data_out), 32'h3C);
    chk("3c_rise", 32'(rise), 32'h3C);
    chk("3c_fall", 32'(fall), 32'h00);
    chk("3c_edge", 32'(edge_any), 32'h1);
    step();
    chk("3c_rise_off", 32'(rise), 32'h00);
    chk("3c_edge_off", 32'(edge_any), 32'h0);

    data_in = 8'hBC;
    step();
    data_in = 8'h3C;
    step();
    step();
    chk("g7_dout", 32'(data_out), 32'hBC);
    chk("g7_rise", 32'(rise), 32'h80);
    step();
    chk("g7_back", 32'(data_out), 32'h3C);
    chk("g7_fall", 32'(fall), 32'h80);
    chk("g7_gcnt", 32'(glitch_count), 32'h0);

    data_in = 8'hC3;
    repeat (3) step();
    chk("c3_dout", 32'(data_out), 32'hC3);
    chk("c3_rise", 32'(rise), 32'hC3);
    chk("c3_fall", 32'(fall), 32'h3C);

    rst = 1'b1;
    step();
    chk_zero_all("rst_hi");
    rst = 1'b0;
    repeat (3) step();
    chk("rel_dout", 32'(data_out), 32'hC3);
    chk("rel_rise", 32'(rise), 32'hC3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
